vmem_write_arbiter: RTL and testbench



---
 rtl/vmem_write_arbiter_pkg.sv | 14 +
 rtl/vmem_write_arbiter_cmd_fifo.sv | 52 +++++
 rtl/vmem_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_vmem_write_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_write_arbiter_pkg.sv
// Shared definitions for the video-memory write arbiter.
// State encoding and default widths shared with the video memory.
package vmem_write_arbiter_pkg;

  localparam int VMA_ADDR_WIDTH  = 10;
  localparam int VMA_COLOR_WIDTH = 3;

  typedef enum logic [1:0] {
    VMA_IDLE  = 2'd0,
    VMA_DRAIN = 2'd1,
    VMA_CLEAR = 2'd2
  } vmaState_e;

endpackage

// File: rtl/vmem_write_arbiter_cmd_fifo.sv
// Write-command FIFO of {address,colour} pairs.
// Pointers carry an extra wrap bit to tell full from empty.
module vmem_cmd_fifo #(
  parameter int ADDR_WIDTH  = 10,
  parameter int COLOR_WIDTH = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iPush,
  input  logic [ADDR_WIDTH-1:0]  iAddress,
  input  logic [COLOR_WIDTH-1:0] iColor,
  input  logic                   iPop,
  output logic [ADDR_WIDTH-1:0]  oAddress,
  output logic [COLOR_WIDTH-1:0] oColor,
  output logic                   oFull,
  output logic                   oEmpty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + COLOR_WIDTH;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW:0]   wrPtr;
  logic [PW:0]   rdPtr;
  logic          doPush;
  logic          doPop;

  assign oEmpty = (wrPtr == rdPtr);
  assign oFull  = (wrPtr[PW] != rdPtr[PW]) &&
                  (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
  assign doPush = iPush && !oFull;
  assign doPop  = iPop && !oEmpty;
  assign {oAddress, oColor} = mem[rdPtr[PW-1:0]];

  // Storage array; contents need no reset
  always_ff @(posedge Clock) begin
    if (doPush) mem[wrPtr[PW-1:0]] <= {iAddress, iColor};
  end

  // Read and write pointers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (PW+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (PW+1)'(1);
    end
  end

endmodule

// File: rtl/vmem_write_arbiter.sv
// Serialises buffered CPU pixel writes and a clear-screen
// sweep onto the single registered video-memory write port.
module vmem_write_arbiter
  import vmem_write_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = VMA_ADDR_WIDTH,
  parameter int COLOR_WIDTH = VMA_COLOR_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_CELLS   = 1024
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iWriteRequest,
  input  logic [ADDR_WIDTH-1:0]  iWriteAddress,
  input  logic [COLOR_WIDTH-1:0] iWriteColor,
  output logic                   oWriteReady,
  input  logic                   iClearRequest,
  input  logic [COLOR_WIDTH-1:0] iClearColor,
  output logic                   oBusy,
  output logic                   oOverflow,
  output logic                   oVideoMemWrite,
  output logic [ADDR_WIDTH-1:0]  oVideoMemAddress,
  output logic [COLOR_WIDTH-1:0] oVideoMemData
);

  localparam logic [ADDR_WIDTH-1:0] LAST_CELL =
    ADDR_WIDTH'(NUM_CELLS - 1);

  vmaState_e              state;
  vmaState_e              stateNext;
  logic [ADDR_WIDTH-1:0]  counter;
  logic [ADDR_WIDTH-1:0]  counterNext;
  logic [COLOR_WIDTH-1:0] clearColor;
  logic [COLOR_WIDTH-1:0] clearColorNext;
  logic                   writeNext;
  logic [ADDR_WIDTH-1:0]  addrNext;
  logic [COLOR_WIDTH-1:0] dataNext;
  logic                   doPush;
  logic                   doPop;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [ADDR_WIDTH-1:0]  fifoAddr;
  logic [COLOR_WIDTH-1:0] fifoColor;

  assign oWriteReady = !fifoFull;
  assign doPush      = iWriteRequest && oWriteReady;
  assign oBusy       = (state != VMA_IDLE) || !fifoEmpty;

  vmem_cmd_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .COLOR_WIDTH(COLOR_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) uFifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .iPush   (doPush),
    .iAddress(iWriteAddress),
    .iColor  (iWriteColor),
    .iPop    (doPop),
    .oAddress(fifoAddr),
    .oColor  (fifoColor),
    .oFull   (fifoFull),
    .oEmpty  (fifoEmpty)
  );

  // Next state, FIFO pop and next write-port values
  always_comb begin
    stateNext      = state;
    counterNext    = counter;
    clearColorNext = clearColor;
    doPop          = 1'b0;
    writeNext      = 1'b0;
    addrNext       = oVideoMemAddress;
    dataNext       = oVideoMemData;
    unique case (state)
      VMA_IDLE: begin
        if (!fifoEmpty) begin
          doPop     = 1'b1;
          writeNext = 1'b1;
          addrNext  = fifoAddr;
          dataNext  = fifoColor;
        end
        if (iClearRequest) begin
          clearColorNext = iClearColor;
          stateNext      = VMA_DRAIN;
        end
      end
      VMA_DRAIN: begin
        if (!fifoEmpty) begin
          doPop     = 1'b1;
          writeNext = 1'b1;
          addrNext  = fifoAddr;
          dataNext  = fifoColor;
        end else if (!doPush) begin
          stateNext   = VMA_CLEAR;
          counterNext = '0;
        end
      end
      VMA_CLEAR: begin
        writeNext   = 1'b1;
        addrNext    = counter;
        dataNext    = clearColor;
        counterNext = counter + ADDR_WIDTH'(1);
        if (counter == LAST_CELL) begin
          stateNext   = VMA_IDLE;
          counterNext = '0;
        end
      end
      default: stateNext = VMA_IDLE;
    endcase
  end

  // State, sweep counter, clear colour and write-port registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state            <= VMA_IDLE;
      counter          <= '0;
      clearColor       <= '0;
      oVideoMemWrite   <= 1'b0;
      oVideoMemAddress <= '0;
      oVideoMemData    <= '0;
    end else begin
      state            <= stateNext;
      counter          <= counterNext;
      clearColor       <= clearColorNext;
      oVideoMemWrite   <= writeNext;
      oVideoMemAddress <= addrNext;
      oVideoMemData    <= dataNext;
    end
  end

  // Sticky flag for commands dropped on a full FIFO
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oOverflow <= 1'b0;
    end else if (iWriteRequest && !oWriteReady) begin
      oOverflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vmem_write_arbiter.sv
// Self-checking bench for vmem_write_arbiter.
// Expected write stream is kept as an ordered queue.
module tb_vmem_write_arbiter;

  typedef struct packed {
    logic [9:0] addr;
    logic [2:0] color;
  } wr_t;

  logic       Clock;
  logic       Reset;
  logic       iWriteRequest;
  logic [9:0] iWriteAddress;
  logic [2:0] iWriteColor;
  logic       oWriteReady;
  logic       iClearRequest;
  logic [2:0] iClearColor;
  logic       oBusy;
  logic       oOverflow;
  logic       oVideoMemWrite;
  logic [9:0] oVideoMemAddress;
  logic [2:0] oVideoMemData;

  int  checks = 0;
  int  errors = 0;
  wr_t exq[$];

  vmem_write_arbiter dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .iWriteRequest   (iWriteRequest),
    .iWriteAddress   (iWriteAddress),
    .iWriteColor     (iWriteColor),
    .oWriteReady     (oWriteReady),
    .iClearRequest   (iClearRequest),
    .iClearColor     (iClearColor),
    .oBusy           (oBusy),
    .oOverflow       (oOverflow),
    .oVideoMemWrite  (oVideoMemWrite),
    .oVideoMemAddress(oVideoMemAddress),
    .oVideoMemData   (oVideoMemData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic expWrite(input logic [9:0] a, input logic [2:0] c);
    wr_t e;
    e.addr  = a;
    e.color = c;
    exq.push_back(e);
  endtask

  task automatic queueSweep(input logic [2:0] c);
    for (int a = 0; a < 1024; a++) expWrite(10'(a), c);
  endtask

  task automatic idleInputs();
    iWriteRequest = 1'b0;
    iWriteAddress = '0;
    iWriteColor   = '0;
    iClearRequest = 1'b0;
    iClearColor   = '0;
  endtask

  // Every write pulse must match the head of the expected stream
  always @(negedge Clock) begin
    if (Reset && oVideoMemWrite) begin
      chk("write_expected", 32'(exq.size() != 0), 1);
      if (exq.size() != 0) begin
        wr_t e;
        e = exq.pop_front();
        chk("write_addr", 32'(oVideoMemAddress), 32'(e.addr));
        chk("write_data", 32'(oVideoMemData), 32'(e.color));
      end
    end
  end

  initial begin
    int  cnt;
    logic found;
    idleInputs();
    Reset = 1'b1;
    #1 Reset = 1'b0;

    // Reset held with random inputs
    repeat (3) begin
      cyc();
      iWriteRequest = 1'($urandom);
      iWriteAddress = 10'($urandom);
      iWriteColor   = 3'($urandom);
      iClearRequest = 1'($urandom);
      iClearColor   = 3'($urandom);
      #1;
      chk("rst_write", 32'(oVideoMemWrite), 0);
      chk("rst_addr", 32'(oVideoMemAddress), 0);
      chk("rst_data", 32'(oVideoMemData), 0);
      chk("rst_overflow", 32'(oOverflow), 0);
      chk("rst_busy", 32'(oBusy), 0);
      chk("rst_ready", 32'(oWriteReady), 1);
    end
    idleInputs();
    @(negedge Clock);
    Reset = 1'b1;
    repeat (10) begin
      cyc();
      chk("idle_write", 32'(oVideoMemWrite), 0);
    end

    // Single write: pulse two edges after the request
    expWrite(10'h123, 3'd5);
    iWriteRequest = 1'b1;
    iWriteAddress = 10'h123;
    iWriteColor   = 3'd5;
    cyc();
    idleInputs();
    chk("single_busy_queued", 32'(oBusy), 1);
    chk("single_no_early", 32'(oVideoMemWrite), 0);
    cyc();
    chk("single_pulse", 32'(oVideoMemWrite), 1);
    chk("single_addr", 32'(oVideoMemAddress), 32'h123);
    chk("single_data", 32'(oVideoMemData), 5);
    chk("single_busy_done", 32'(oBusy), 0);
    cyc();
    chk("single_one_pulse", 32'(oVideoMemWrite), 0);
    repeat (3) cyc();

    // Clear with colour 2 on an empty FIFO
    queueSweep(3'd2);
    iClearRequest = 1'b1;
    iClearColor   = 3'd2;
    cyc();
    idleInputs();
    chk("clear_busy", 32'(oBusy), 1);
    cyc();
    chk("clear_no_early", 32'(oVideoMemWrite), 0);
    cnt = 0;
    for (int k = 0; k < 1024; k++) begin
      cyc();
      if (oVideoMemWrite) cnt++;
    end
    chk("clear_run_len", 32'(cnt), 1024);
    chk("clear_last_addr", 32'(oVideoMemAddress), 32'h3ff);
    chk("clear_last_data", 32'(oVideoMemData), 2);
    chk("clear_busy_fall", 32'(oBusy), 0);
    cyc();
    chk("clear_stopped", 32'(oVideoMemWrite), 0);
    chk("clear_sb_empty", 32'(exq.size()), 0);
    repeat (3) cyc();

    // Ordering: queued write precedes the sweep, overflow on full
    expWrite(10'h3ff, 3'd7);
    queueSweep(3'd1);
    iWriteRequest = 1'b1;
    iWriteAddress = 10'h3ff;
    iWriteColor   = 3'd7;
    iClearRequest = 1'b1;
    iClearColor   = 3'd1;
    cyc();
    idleInputs();
    cyc();
    chk("order_first_write", 32'(oVideoMemWrite), 1);
    chk("order_first_addr", 32'(oVideoMemAddress), 32'h3ff);
    chk("order_first_data", 32'(oVideoMemData), 7);
    cyc();
    chk("order_gap", 32'(oVideoMemWrite), 0);
    for (int i = 0; i < 6; i++) begin
      chk("order_ready", 32'(oWriteReady), 32'(i < 4));
      iWriteRequest = 1'b1;
      iWriteAddress = 10'h010 + 10'(i);
      iWriteColor   = 3'(i);
      iClearRequest = (i == 2);
      iClearColor   = 3'd4;
      if (i < 4) expWrite(10'h010 + 10'(i), 3'(i));
      cyc();
      idleInputs();
    end
    chk("order_ready_low", 32'(oWriteReady), 0);
    chk("order_overflow", 32'(oOverflow), 1);
    chk("order_busy", 32'(oBusy), 1);
    for (int k = 0; k < 1200 && oBusy; k++) cyc();
    chk("order_drained", 32'(oBusy), 0);
    repeat (5) cyc();
    chk("order_sb_empty", 32'(exq.size()), 0);
    chk("order_overflow_sticky", 32'(oOverflow), 1);

    // Reset in the middle of a sweep
    queueSweep(3'd3);
    iClearRequest = 1'b1;
    iClearColor   = 3'd3;
    cyc();
    idleInputs();
    found = 1'b0;
    for (int k = 0; k < 1100 && !found; k++) begin
      @(negedge Clock);
      if (oVideoMemWrite && oVideoMemAddress == 10'h080) found = 1'b1;
    end
    chk("midclr_found", 32'(found), 1);
    #2 Reset = 1'b0;
    #1;
    chk("midclr_write_drop", 32'(oVideoMemWrite), 0);
    chk("midclr_addr", 32'(oVideoMemAddress), 0);
    chk("midclr_overflow", 32'(oOverflow), 0);
    exq.delete();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (10) begin
      cyc();
      chk("midclr_no_write", 32'(oVideoMemWrite), 0);
    end
    chk("midclr_busy", 32'(oBusy), 0);
    chk("midclr_ready", 32'(oWriteReady), 1);
    chk("midclr_ovf_after", 32'(oOverflow), 0);

    chk("final_sb_empty", 32'(exq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
